// File: rtl/game_logic_if.sv
// game_logic_if: predictor boxes, game controls and pixel stream into the overlay block
interface game_logic_if;
  logic predict_valid;
  logic start;
  logic enter_game;
  logic ThisFrameEnd;
  logic [1:0][10:0] left;
  logic [1:0][10:0] right;
  logic [1:0][10:0] up;
  logic [1:0][10:0] down;
  logic [10:0] x;
  logic [10:0] y;
  logic [2:0][7:0] i_rgb;
  logic [2:0][7:0] o_rgb;
  modport master (
    output predict_valid, start, enter_game, ThisFrameEnd,
    output left, right, up, down, x, y, i_rgb,
    input o_rgb
  );
  modport slave (
    input predict_valid, start, enter_game, ThisFrameEnd,
    input left, right, up, down, x, y, i_rgb,
    output o_rgb
  );
endinterface

// File: rtl/game_logic.sv
// game_logic: falling-target hand game state plus combinational pixel overlay
module game_logic #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int TARGET_SIZE = 32,
  parameter int FALL_SPEED = 4,
  parameter int GAME_FRAMES = 2560,
  parameter int LIVES = 3
) (
  input logic i_clk,
  input logic i_rst,
  game_logic_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam logic [10:0] X_MAX = 11'(H_RES);
  localparam logic [10:0] MISS_Y = 11'(V_RES - TARGET_SIZE);
  localparam logic [10:0] SBAR_Y = 11'(V_RES - 8);
  localparam logic [10:0] TS1 = 11'(TARGET_SIZE - 1);
  localparam logic [10:0] FALL = 11'(FALL_SPEED);
  localparam logic [15:0] T0 = 16'(GAME_FRAMES);
  localparam logic [7:0] L0 = 8'(LIVES);
  localparam logic [23:0] GREEN = 24'h00ff00;
  localparam logic [23:0] BLUE = 24'h0000ff;
  localparam logic [23:0] RED = 24'hff0000;
  localparam logic [23:0] WHITE = 24'hffffff;
  localparam logic [23:0] YELLOW = 24'hffff00;
  state_t state, state_n;
  logic [15:0] lfsr;
  logic [1:0][10:0] bl, br, bu, bd;
  logic [1:0] bv;
  logic [7:0] score, lives, lives_dec;
  logic [15:0] timer, timer_dec;
  logic [10:0] tx, ty, spawn_x;
  logic [1:0] ne, hit_k, in_b, edg;
  logic hit, miss, init, upd, in_t, tbar, sbar;
  for (genvar k = 0; k < 2; k++) begin : g_box
    // a box never loaded since reset is treated like an empty one
    assign ne[k] = bv[k] && bl[k] <= br[k] && bu[k] <= bd[k];
    assign hit_k[k] = ne[k] && tx <= br[k] && tx + TS1 >= bl[k] && ty <= bd[k] && ty + TS1 >= bu[k];
    assign in_b[k] = ne[k] && bus.x >= bl[k] && bus.x <= br[k] && bus.y >= bu[k] && bus.y <= bd[k];
    assign edg[k] = in_b[k] && (bus.x - bl[k] <= 11'd2 || br[k] - bus.x <= 11'd2 ||
                                bus.y - bu[k] <= 11'd2 || bd[k] - bus.y <= 11'd2);
  end
  assign hit = |hit_k;
  assign miss = !hit && ty >= MISS_Y;
  assign spawn_x = 11'd64 + 11'(lfsr[8:0]);
  assign timer_dec = timer == 16'd0 ? 16'd0 : timer - 16'd1;
  assign lives_dec = miss && lives != 8'd0 ? lives - 8'd1 : lives;
  always_comb begin
    state_n = state;
    init = 1'b0;
    upd = 1'b0;
    case (state)
      IDLE: if (bus.start && bus.enter_game) begin
        state_n = PLAY;
        init = 1'b1;
      end
      PLAY: if (bus.ThisFrameEnd) begin
        upd = 1'b1;
        state_n = timer_dec == 16'd0 || lives_dec == 8'd0 ? OVER : PLAY;
      end
      OVER: if (bus.start && bus.enter_game) begin
        state_n = PLAY;
        init = 1'b1;
      end else if (!bus.enter_game) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      lfsr <= 16'hace1;
      bl <= '0;
      br <= '0;
      bu <= '0;
      bd <= '0;
      bv <= '0;
      score <= '0;
      lives <= L0;
      timer <= T0;
      tx <= '0;
      ty <= '0;
    end else begin
      state <= state_n;
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (bus.predict_valid) begin
        bl <= bus.left;
        br <= bus.right;
        bu <= bus.up;
        bd <= bus.down;
        bv <= 2'b11;
      end
      if (init) begin
        score <= '0;
        lives <= L0;
        timer <= T0;
        tx <= spawn_x;
        ty <= '0;
      end else if (upd) begin
        timer <= timer_dec;
        lives <= lives_dec;
        if (hit && score != 8'hff) score <= score + 8'd1;
        tx <= hit || miss ? spawn_x : tx;
        ty <= hit || miss ? 11'd0 : ty + FALL;
      end
    end
  end
  assign in_t = state == PLAY && bus.x >= tx && bus.x <= tx + TS1 && bus.y >= ty && bus.y <= ty + TS1;
  assign tbar = state == PLAY && bus.y < 11'd8 && bus.x < X_MAX && 16'(bus.x) < (timer >> 2);
  // bars are clipped to the visible width so a saturated score stays on screen
  assign sbar = state != IDLE && bus.y >= SBAR_Y && bus.x < X_MAX && bus.x < {1'b0, score, 2'b00};
  assign bus.o_rgb = edg[0] ? GREEN : edg[1] ? BLUE : in_t ? RED : tbar ? WHITE : sbar ? YELLOW :
                     state == OVER ? {bus.i_rgb[2] >> 1, bus.i_rgb[1] >> 1, bus.i_rgb[0] >> 1} : bus.i_rgb;
endmodule

// File: tb/tb_game_logic.sv
// tb_game_logic: scoreboard bench for game_logic overlay and game FSM
module tb_game_logic;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] m_lfsr;
  logic [10:0] spawn_x;
  logic [23:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  game_logic_if bus();
  game_logic dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic b;
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1;
    return (v >> 1) | (16'(b) << 15);
  endfunction
  always @(posedge clk) m_lfsr <= rst ? 16'hace1 : lfsr_step(m_lfsr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic probe(input string tag, input int px, input int py, input logic [23:0] rgb, input logic [23:0] exp);
    bus.x = 11'(px);
    bus.y = 11'(py);
    bus.i_rgb = rgb;
    exp_q.push_back(exp);
    #1;
    chk(tag, 32'(bus.o_rgb), 32'(exp_q.pop_front()));
  endtask
  task automatic load(input int l0, r0, u0, d0, l1, r1, u1, d1);
    bus.left = {11'(l1), 11'(l0)};
    bus.right = {11'(r1), 11'(r0)};
    bus.up = {11'(u1), 11'(u0)};
    bus.down = {11'(d1), 11'(d0)};
    bus.predict_valid = 1'b1;
    tick(1);
    bus.predict_valid = 1'b0;
  endtask
  task automatic start_game;
    spawn_x = 11'd64 + 11'(m_lfsr[8:0]);
    bus.start = 1'b1;
    bus.enter_game = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask
  initial begin
    bus.predict_valid = 0;
    bus.start = 0;
    bus.enter_game = 0;
    bus.ThisFrameEnd = 0;
    bus.left = '0;
    bus.right = '0;
    bus.up = '0;
    bus.down = '0;
    bus.x = '0;
    bus.y = '0;
    bus.i_rgb = '0;
    tick(2);
    rst = 1'b0;
    chk("reset_state", 32'(dut.state), 0);
    probe("reset_px", 10, 10, 24'h010203, 24'h010203);
    probe("reset_origin", 0, 0, 24'h123456, 24'h123456);
    load(100, 200, 100, 200, 1, 0, 0, 0);
    probe("box0_left_edge", 100, 150, 24'h111111, 24'h00ff00);
    probe("box0_inside", 150, 150, 24'h111111, 24'h111111);
    probe("box0_corner", 200, 200, 24'h111111, 24'h00ff00);
    load(100, 200, 100, 200, 100, 300, 100, 300);
    probe("box0_over_box1", 100, 150, 24'h222222, 24'h00ff00);
    probe("box1_edge", 300, 250, 24'h222222, 24'h0000ff);
    probe("box1_inside", 250, 250, 24'h222222, 24'h222222);
    load(1, 0, 0, 0, 5, 9, 9, 5);
    bus.ThisFrameEnd = 1'b1;
    start_game;
    chk("play_state", 32'(dut.state), 1);
    chk("spawn_ty", 32'(dut.ty), 0);
    probe("target_spawn", int'(spawn_x), 0, 24'h333333, 24'hff0000);
    probe("timer_bar", int'(spawn_x) - 1, 0, 24'h333333, 24'hffffff);
    probe("timer_bar_end", 639, 7, 24'h333333, 24'hffffff);
    tick(1);
    chk("fall_one", 32'(dut.ty), 4);
    probe("below_timer_bar", 0, 8, 24'h444444, 24'h444444);
    tick(111);
    chk("fall_bottom", 32'(dut.ty), 448);
    chk("lives_before_miss", 32'(dut.lives), 3);
    probe("target_bottom", int'(spawn_x) + 31, 479, 24'h555555, 24'hff0000);
    probe("right_of_target", int'(spawn_x) + 32, 460, 24'h555555, 24'h555555);
    tick(1);
    chk("miss_lives", 32'(dut.lives), 2);
    chk("miss_respawn", 32'(dut.ty), 0);
    tick(226);
    chk("over_state", 32'(dut.state), 2);
    chk("over_timer", 32'(dut.timer), 2560 - 339);
    probe("over_dim", 50, 50, 24'h643207, 24'h321903);
    bus.ThisFrameEnd = 1'b0;
    load(50, 2000, 0, 2000, 1, 0, 0, 0);
    start_game;
    chk("restart_state", 32'(dut.state), 1);
    chk("restart_score", 32'(dut.score), 0);
    bus.ThisFrameEnd = 1'b1;
    tick(1);
    chk("hit_score", 32'(dut.score), 1);
    chk("hit_respawn", 32'(dut.ty), 0);
    chk("hit_lives", 32'(dut.lives), 3);
    probe("score_bar", 0, 475, 24'h666666, 24'hffff00);
    probe("score_bar_end", 3, 475, 24'h666666, 24'hffff00);
    probe("score_bar_past", 4, 475, 24'h666666, 24'h666666);
    tick(2559);
    bus.ThisFrameEnd = 1'b0;
    chk("timeout_state", 32'(dut.state), 2);
    chk("timeout_timer", 32'(dut.timer), 0);
    chk("score_saturated", 32'(dut.score), 255);
    probe("over_score_bar", 639, 475, 24'h777777, 24'hffff00);
    bus.enter_game = 1'b0;
    tick(1);
    chk("leave_idle", 32'(dut.state), 0);
    start_game;
    bus.ThisFrameEnd = 1'b1;
    tick(3);
    bus.ThisFrameEnd = 1'b0;
    chk("midgame_score", 32'(dut.score), 3);
    rst = 1'b1;
    bus.start = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_state", 32'(dut.state), 0);
    chk("rst_score", 32'(dut.score), 0);
    probe("rst_px", 100, 150, 24'h888888, 24'h888888);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
